window_spill_fill_engine: RTL and testbench



---
 rtl/window_spill_fill_engine.sv | 145 ++++++++++++++
 tb/tb_window_spill_fill_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/window_spill_fill_engine.sv
// Window overflow/underflow service engine: spills or fills the 16 local+in
// registers of one window to/from the memory stack, then rotates the WIM.
module window_spill_fill_engine #(
    parameter int NWINDOWS = 4,
    parameter int WINREGS  = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        ovfReq,
    input  logic        unfReq,
    input  logic [1:0]  winIdx,
    input  logic [31:0] stackPtr,
    input  logic [31:0] wimIn,
    input  logic [31:0] regRdData,
    input  logic        memAck,
    input  logic [31:0] memRdData,
    output logic        busy,
    output logic        done,
    output logic [1:0]  regWinSel,
    output logic [3:0]  regAddr,
    output logic        regWe,
    output logic [31:0] regWrData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWrData,
    output logic [31:0] wimOut,
    output logic        wimWe
);

    typedef enum logic [2:0] {
        IDLE,
        SPILL_RD,
        SPILL_WR,
        FILL_RD,
        FILL_WR,
        WIM_UPD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  win_q;
    logic [31:0] base_q;
    logic [31:0] wim_q;
    logic [3:0]  cnt_q;
    logic        spill_q;

    logic        last;
    logic [31:0] addr;
    logic [1:0]  nbr;
    logic [31:0] wim_next;

    assign last      = (cnt_q == 4'(WINREGS - 1));
    assign addr      = base_q + {26'd0, cnt_q, 2'b00};
    assign regWinSel = win_q;
    assign regAddr   = cnt_q;

    // The neighbour window becomes the new invalid window: one ahead after a
    // spill, one behind after a fill, wrapping within NWINDOWS.
    always_comb begin
        nbr      = (spill_q ? (win_q + 2'd1) : (win_q - 2'd1)) & 2'(NWINDOWS - 1);
        wim_next = wim_q;
        wim_next[win_q] = 1'b0;
        wim_next[nbr]   = 1'b1;
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        regWe   = 1'b0;
        memReq  = 1'b0;
        memWe   = 1'b0;
        memAddr = 32'd0;
        wimOut  = 32'd0;
        wimWe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ovfReq)      state_d = SPILL_RD;
                else if (unfReq) state_d = FILL_RD;
            end
            SPILL_RD: state_d = SPILL_WR;
            SPILL_WR: begin
                memReq  = 1'b1;
                memWe   = 1'b1;
                memAddr = addr;
                if (memAck) state_d = last ? WIM_UPD : SPILL_RD;
            end
            FILL_RD: begin
                memReq  = 1'b1;
                memAddr = addr;
                if (memAck) state_d = FILL_WR;
            end
            FILL_WR: begin
                regWe   = 1'b1;
                state_d = last ? WIM_UPD : FILL_RD;
            end
            WIM_UPD: begin
                wimWe   = 1'b1;
                wimOut  = wim_next;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all registered state so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q   <= IDLE;
            win_q     <= 2'd0;
            base_q    <= 32'd0;
            wim_q     <= 32'd0;
            cnt_q     <= 4'd0;
            spill_q   <= 1'b0;
            memWrData <= 32'd0;
            regWrData <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (ovfReq || unfReq) begin
                        win_q   <= winIdx;
                        base_q  <= stackPtr & ~32'h3;
                        wim_q   <= wimIn;
                        cnt_q   <= 4'd0;
                        spill_q <= ovfReq;
                    end
                end
                SPILL_RD: memWrData <= regRdData;
                SPILL_WR: if (memAck && !last) cnt_q <= cnt_q + 4'd1;
                FILL_RD:  if (memAck) regWrData <= memRdData;
                FILL_WR:  if (!last) cnt_q <= cnt_q + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_window_spill_fill_engine.sv
// Directed bench for window_spill_fill_engine: a register-file model returns
// 0xA0+regAddr, memory acks are driven with a chosen number of wait cycles.
module tb_window_spill_fill_engine;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        ovfReq, unfReq;
    logic [1:0]  winIdx;
    logic [31:0] stackPtr, wimIn, regRdData, memRdData;
    logic        memAck;
    logic        busy, done, regWe, memReq, memWe, wimWe;
    logic [1:0]  regWinSel;
    logic [3:0]  regAddr;
    logic [31:0] regWrData, memAddr, memWrData, wimOut;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign regRdData = 32'hA0 + {28'd0, regAddr};

    window_spill_fill_engine #(.NWINDOWS(4), .WINREGS(16)) dut (
        .Clk(Clk), .Clr(Clr), .ovfReq(ovfReq), .unfReq(unfReq),
        .winIdx(winIdx), .stackPtr(stackPtr), .wimIn(wimIn),
        .regRdData(regRdData), .memAck(memAck), .memRdData(memRdData),
        .busy(busy), .done(done), .regWinSel(regWinSel), .regAddr(regAddr),
        .regWe(regWe), .regWrData(regWrData), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWrData(memWrData), .wimOut(wimOut), .wimWe(wimWe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_winsel"},    regWinSel, 0);
        check({tag, "_regaddr"},   regAddr,   0);
        check({tag, "_regwe"},     regWe,     0);
        check({tag, "_regwrdata"}, regWrData, 0);
        check({tag, "_memreq"},    memReq,    0);
        check({tag, "_memwe"},     memWe,     0);
        check({tag, "_memaddr"},   memAddr,   0);
        check({tag, "_memwrdata"}, memWrData, 0);
        check({tag, "_wimout"},    wimOut,    0);
        check({tag, "_wimwe"},     wimWe,     0);
    endtask

    // Runs one complete trap service from request to idle. abort_at >= 0
    // resets the engine in the first SPILL_WR cycle of that register.
    task automatic run_op(input string tag, input bit spill, input bit both,
                          input bit mid_pulse, input logic [1:0] win,
                          input logic [31:0] sp, input logic [31:0] wim_in,
                          input int waits, input logic [31:0] exp_wim,
                          input int abort_at);
        logic [31:0] base;
        logic [31:0] data;
        int seen;
        base     = sp & ~32'h3;
        ovfReq   = spill;
        unfReq   = !spill || both;
        winIdx   = win;
        stackPtr = sp;
        wimIn    = wim_in;
        tick();
        ovfReq = 1'b0;
        unfReq = 1'b0;
        winIdx = ~win;
        stackPtr = 32'h5555_5555;
        wimIn  = 32'hFFFF_FFFF;
        check({tag, "_busy_c1"}, busy, 1);
        for (int r = 0; r < 16; r++) begin
            data = spill ? (32'hA0 + r) : (32'hC0DE_0000 + r);
            if (spill) begin
                check({tag, "_rd_memreq"}, memReq, 0);
                check({tag, "_rd_regaddr"}, regAddr, r);
                check({tag, "_rd_winsel"}, regWinSel, win);
                if (mid_pulse && r == 7) ovfReq = 1'b1;
                tick();
                ovfReq = 1'b0;
                for (int w = 0; w <= waits; w++) begin
                    check({tag, "_wr_memreq"}, memReq, 1);
                    check({tag, "_wr_memwe"}, memWe, 1);
                    check({tag, "_wr_addr"}, memAddr, base + 4 * r);
                    check({tag, "_wr_data"}, memWrData, data);
                    check({tag, "_wr_regwe"}, regWe, 0);
                    if (r == abort_at) begin
                        Clr = 1'b0;
                        tick();
                        Clr = 1'b1;
                        check_all_zero({tag, "_abort"});
                        seen = 0;
                        for (int k = 0; k < 40; k++) begin
                            tick();
                            if (wimWe || done || memReq) seen++;
                        end
                        check({tag, "_abort_quiet"}, seen, 0);
                        return;
                    end
                    memAck = (w == waits);
                    tick();
                    memAck = 1'b0;
                end
            end else begin
                for (int w = 0; w <= waits; w++) begin
                    check({tag, "_rd_memreq"}, memReq, 1);
                    check({tag, "_rd_memwe"}, memWe, 0);
                    check({tag, "_rd_addr"}, memAddr, base + 4 * r);
                    check({tag, "_rd_regwe"}, regWe, 0);
                    memAck    = (w == waits);
                    memRdData = (w == waits) ? data : 32'hDEAD_BEEF;
                    tick();
                    memAck    = 1'b0;
                    memRdData = 32'h0;
                end
                check({tag, "_wr_regwe"}, regWe, 1);
                check({tag, "_wr_regaddr"}, regAddr, r);
                check({tag, "_wr_winsel"}, regWinSel, win);
                check({tag, "_wr_data"}, regWrData, data);
                check({tag, "_wr_memreq"}, memReq, 0);
                tick();
            end
        end
        check({tag, "_wimwe"}, wimWe, 1);
        check({tag, "_wimout"}, wimOut, exp_wim);
        check({tag, "_memreq_wim"}, memReq, 0);
        check({tag, "_done_early"}, done, 0);
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_wimwe_off"}, wimWe, 0);
        check({tag, "_busy_done"}, busy, 1);
        tick();
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_done_off"}, done, 0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done || busy) seen++;
        end
        check({tag, "_single_done"}, seen, 0);
    endtask

    initial begin
        Clr = 1'b0;
        ovfReq = 1'b0; unfReq = 1'b0; winIdx = 2'd0;
        stackPtr = 32'h0; wimIn = 32'h0; memAck = 1'b0; memRdData = 32'h0;

        // Reset with random inputs
        for (int k = 0; k < 2; k++) begin
            ovfReq    = 1'($urandom);
            unfReq    = 1'($urandom);
            winIdx    = 2'($urandom);
            stackPtr  = $urandom;
            wimIn     = $urandom;
            memAck    = 1'($urandom);
            memRdData = $urandom;
            tick();
        end
        check_all_zero("reset");
        ovfReq = 1'b0; unfReq = 1'b0; memAck = 1'b0;
        Clr = 1'b1;
        tick();
        check_all_zero("idle");

        // Zero-wait spill of window 1
        run_op("spill0", 1'b1, 1'b0, 1'b0, 2'd1, 32'h1000, 32'h2, 0, 32'h4, -1);

        // Fill of window 0 with two wait cycles per access, WIM wraps to bit 3
        run_op("fill2", 1'b0, 1'b0, 1'b0, 2'd0, 32'h2003, 32'h1, 2, 32'h8, -1);

        // Both requests together, second ovfReq mid-spill; upper WIM bits pass through
        run_op("both", 1'b1, 1'b1, 1'b1, 2'd3, 32'h4000, 32'hABCD_0008, 0, 32'hABCD_0001, -1);

        // Reset after the 5th ack, then a full fill
        run_op("abort", 1'b1, 1'b0, 1'b0, 2'd2, 32'h6000, 32'h4, 0, 32'h0, 5);
        run_op("refill", 1'b0, 1'b0, 1'b0, 2'd2, 32'h3000, 32'h4, 1, 32'h2, -1);

        // Address wrap past 2^32
        run_op("wrap", 1'b1, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFF0, 32'h1, 1, 32'h2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
